// File: rtl/can_tx_serializer.sv
// CAN transmit serializer: SOF..CRC MSB-first, one bit per tick; CRC stage only with CAN_TXSER_CRC_EN.
// Latency: SOF presented the cycle after load; each bit advances on a tick edge; done pulses as busy drops.
// Backpressure: load is ignored while busy (no queueing); abort cancels to idle without done.
module can_tx_serializer (
    input  logic        clock,
    input  logic        reset,
    input  logic [38:0] message,
    input  logic        extended,
    input  logic [3:0]  tmlen,
    input  logic [63:0] data,
    input  logic        load,
    input  logic        tick,
    input  logic        abort,
    output logic        txbit,
    output logic        busy,
    output logic        done,
    output logic [6:0]  bitcnt
);

    typedef enum logic [1:0] {IDLE, HDR, DATA, CRC} state_t;

    state_t      state_q, state_d;
    logic [38:0] hdr_sh_q;
    logic [63:0] data_sh_q;
    logic        ext_q;
    logic [3:0]  len_q;
    logic [6:0]  bitcnt_q;
    logic        done_q, done_d;

    logic [3:0]  len_clip;
    logic [6:0]  hdr_last_idx;
    logic [6:0]  data_last_idx;
    logic        advance;

    assign len_clip      = (tmlen > 4'd8) ? 4'd8 : tmlen;
    assign hdr_last_idx  = ext_q ? 7'd38 : 7'd18;
    // Data occupies the indices directly after the header, 8 bits per byte.
    assign data_last_idx = hdr_last_idx + {len_q, 3'b000};
    assign advance       = tick && !abort;

`ifdef CAN_TXSER_CRC_EN
    logic [14:0] crc_q;
    logic [14:0] crc_sh_q;
    logic [14:0] crc_fold;
    logic [6:0]  crc_last_idx;
    logic        crc_nxt;

    assign crc_last_idx = data_last_idx + 7'd15;
    assign crc_nxt      = txbit ^ crc_q[14];
    assign crc_fold     = {crc_q[13:0], 1'b0} ^ (crc_nxt ? 15'h4599 : 15'h0000);
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        txbit   = 1'b1;
        busy    = 1'b1;
        case (state_q)
            IDLE: begin
                busy = 1'b0;
                if (load) begin
                    state_d = HDR;
                end
            end
            HDR: begin
                txbit = hdr_sh_q[38];
                if (abort) begin
                    state_d = IDLE;
                end else if (tick && (bitcnt_q == hdr_last_idx)) begin
                    if (len_q != 4'd0) begin
                        state_d = DATA;
                    end else begin
`ifdef CAN_TXSER_CRC_EN
                        state_d = CRC;
`else
                        state_d = IDLE;
                        done_d  = 1'b1;
`endif
                    end
                end
            end
            DATA: begin
                txbit = data_sh_q[63];
                if (abort) begin
                    state_d = IDLE;
                end else if (tick && (bitcnt_q == data_last_idx)) begin
`ifdef CAN_TXSER_CRC_EN
                    state_d = CRC;
`else
                    state_d = IDLE;
                    done_d  = 1'b1;
`endif
                end
            end
            default: begin
`ifdef CAN_TXSER_CRC_EN
                txbit = crc_sh_q[14];
                if (abort) begin
                    state_d = IDLE;
                end else if (tick && (bitcnt_q == crc_last_idx)) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
`else
                busy    = 1'b0;
                state_d = IDLE;
`endif
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            hdr_sh_q  <= '0;
            data_sh_q <= '0;
            ext_q     <= 1'b0;
            len_q     <= '0;
            bitcnt_q  <= '0;
            done_q    <= 1'b0;
        end else begin
            done_q <= done_d;

            if (state_d == IDLE) begin
                bitcnt_q <= '0;
            end else if (state_q != IDLE && tick) begin
                bitcnt_q <= bitcnt_q + 7'd1;
            end

            if (state_q == IDLE) begin
                if (load) begin
                    // Basic frames drop bits 37:18 so the shifter stays contiguous.
                    hdr_sh_q  <= extended ? message : {message[38], message[17:0], 20'b0};
                    data_sh_q <= data;
                    ext_q     <= extended;
                    len_q     <= len_clip;
                end
            end else if (advance) begin
                if (state_q == HDR) begin
                    hdr_sh_q <= {hdr_sh_q[37:0], 1'b0};
                end
                if (state_q == DATA) begin
                    data_sh_q <= {data_sh_q[62:0], 1'b0};
                end
            end
        end
    end

`ifdef CAN_TXSER_CRC_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            crc_q    <= '0;
            crc_sh_q <= '0;
        end else begin
            if (state_q == IDLE) begin
                crc_q <= '0;
            end else if (advance && (state_q == HDR || state_q == DATA)) begin
                crc_q <= crc_fold;
            end

            // The shift copy takes the final folded value; crc_q stays frozen.
            if (state_d == CRC && state_q != CRC) begin
                crc_sh_q <= crc_fold;
            end else if (state_q == CRC && advance) begin
                crc_sh_q <= {crc_sh_q[13:0], 1'b0};
            end
        end
    end
`endif

    assign done   = done_q;
    assign bitcnt = bitcnt_q;

endmodule

// File: tb/tb_can_tx_serializer.sv
// Directed bench for can_tx_serializer; expectations follow the CAN_TXSER_CRC_EN setting of the build.
module tb_can_tx_serializer;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [38:0] message = '0;
    logic        extended = 1'b0;
    logic [3:0]  tmlen = '0;
    logic [63:0] data = '0;
    logic        load = 1'b0;
    logic        tick = 1'b0;
    logic        abort = 1'b0;
    logic        txbit;
    logic        busy;
    logic        done;
    logic [6:0]  bitcnt;

    int total = 0;
    int bad = 0;

`ifdef CAN_TXSER_CRC_EN
    localparam int CRC_BITS = 15;
`else
    localparam int CRC_BITS = 0;
`endif

    can_tx_serializer dut (
        .clock(clock), .reset(reset), .message(message), .extended(extended),
        .tmlen(tmlen), .data(data), .load(load), .tick(tick), .abort(abort),
        .txbit(txbit), .busy(busy), .done(done), .bitcnt(bitcnt)
    );

    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic int frame_len(input logic ext, input logic [3:0] tl);
        int l;
        l = (tl > 4'd8) ? 8 : int'(tl);
        return (ext ? 39 : 19) + 8 * l + CRC_BITS;
    endfunction

    // Reference stream: bit i of the frame in element i.
    function automatic logic [127:0] exp_stream(input logic [38:0] msg, input logic ext,
                                                input logic [3:0] tl, input logic [63:0] d);
        logic [127:0] s;
        logic [14:0]  crc;
        logic         nxt;
        int           n;
        int           l;
        s   = '0;
        crc = '0;
        l   = (tl > 4'd8) ? 8 : int'(tl);
        if (ext) begin
            for (int k = 0; k < 39; k++) s[k] = msg[38-k];
            n = 39;
        end else begin
            s[0] = msg[38];
            for (int k = 1; k < 19; k++) s[k] = msg[18-k];
            n = 19;
        end
        for (int k = 0; k < 8 * l; k++) s[n+k] = d[63-k];
        n = n + 8 * l;
        for (int k = 0; k < n; k++) begin
            nxt = s[k] ^ crc[14];
            crc = {crc[13:0], 1'b0};
            if (nxt) crc = crc ^ 15'h4599;
        end
        if (CRC_BITS != 0) begin
            for (int k = 0; k < 15; k++) s[n+k] = crc[14-k];
        end
        return s;
    endfunction

    task automatic do_load(input logic [38:0] msg, input logic ext, input logic [3:0] tl,
                           input logic [63:0] d, input logic with_tick);
        @(negedge clock);
        message  = msg;
        extended = ext;
        tmlen    = tl;
        data     = d;
        load     = 1'b1;
        tick     = with_tick;
        @(posedge clock);
        @(negedge clock);
        load = 1'b0;
        tick = 1'b0;
    endtask

    task automatic give_tick();
        tick = 1'b1;
        @(posedge clock);
        @(negedge clock);
        tick = 1'b0;
    endtask

    // Records the serial stream over n ticks; starts and ends on a falling edge.
    task automatic capture(input int n, output logic [127:0] obs, output logic cnt_ok,
                           output logic busy_ok, output logic early_done,
                           output logic done_end, output logic busy_end);
        obs        = '0;
        cnt_ok     = 1'b1;
        busy_ok    = 1'b1;
        early_done = 1'b0;
        for (int i = 0; i < n; i++) begin
            obs[i] = txbit;
            if (bitcnt !== 7'(i)) cnt_ok = 1'b0;
            if (busy !== 1'b1) busy_ok = 1'b0;
            if (done !== 1'b0) early_done = 1'b1;
            give_tick();
        end
        done_end = done;
        busy_end = busy;
    endtask

    task automatic test_reset();
        @(negedge clock);
        total++; if (txbit !== 1'b1) begin bad++; $display("FAIL reset_txbit got=%b want=1", txbit); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done); end
        total++; if (bitcnt !== 7'd0) begin bad++; $display("FAIL reset_bitcnt got=%0d want=0", bitcnt); end
        reset = 1'b0;
        @(negedge clock);
        tick = 1'b1;
        @(posedge clock);
        @(negedge clock);
        tick = 1'b0;
        total++; if (busy !== 1'b0 || bitcnt !== 7'd0) begin
            bad++; $display("FAIL idle_tick busy=%b bitcnt=%0d want busy=0 bitcnt=0", busy, bitcnt);
        end
    endtask

    task automatic test_basic_zero();
        logic [127:0] obs;
        logic cnt_ok, busy_ok, early_done, done_end, busy_end;
        do_load(39'h0, 1'b0, 4'd0, 64'h0, 1'b0);
        capture((CRC_BITS != 0) ? 34 : 19, obs, cnt_ok, busy_ok, early_done, done_end, busy_end);
        total++; if (obs !== 128'h0) begin bad++; $display("FAIL zero_stream got=%h want=0", obs); end
        total++; if (cnt_ok !== 1'b1) begin bad++; $display("FAIL zero_bitcnt_seq got=%b want=1", cnt_ok); end
        total++; if (busy_ok !== 1'b1 || early_done !== 1'b0) begin
            bad++; $display("FAIL zero_busy_window busy_ok=%b early_done=%b want 1/0", busy_ok, early_done);
        end
        total++; if (done_end !== 1'b1 || busy_end !== 1'b0) begin
            bad++; $display("FAIL zero_done done=%b busy=%b want 1/0", done_end, busy_end);
        end
        @(negedge clock);
        total++; if (done !== 1'b0) begin bad++; $display("FAIL zero_done_width got=%b want=0", done); end
    endtask

    task automatic test_ext_clip();
        logic [127:0] obs;
        logic [63:0]  fld;
        logic cnt_ok, busy_ok, early_done, done_end, busy_end;
        logic [38:0] msg;
        msg = 39'h12_3456_789A;
        do_load(msg, 1'b1, 4'd9, 64'h0123_4567_89AB_CDEF, 1'b0);
        capture((CRC_BITS != 0) ? 118 : 103, obs, cnt_ok, busy_ok, early_done, done_end, busy_end);
        for (int k = 0; k < 64; k++) fld[63-k] = obs[39+k];
        total++; if (fld !== 64'h0123_4567_89AB_CDEF) begin
            bad++; $display("FAIL clip_data_field got=%h want=0123456789abcdef", fld);
        end
        total++; if (obs !== exp_stream(msg, 1'b1, 4'd9, 64'h0123_4567_89AB_CDEF)) begin
            bad++; $display("FAIL clip_stream got=%h want=%h", obs, exp_stream(msg, 1'b1, 4'd9, 64'h0123_4567_89AB_CDEF));
        end
        total++; if (cnt_ok !== 1'b1 || busy_ok !== 1'b1 || early_done !== 1'b0) begin
            bad++; $display("FAIL clip_window cnt=%b busy=%b early=%b want 1/1/0", cnt_ok, busy_ok, early_done);
        end
        total++; if (done_end !== 1'b1 || busy_end !== 1'b0) begin
            bad++; $display("FAIL clip_done done=%b busy=%b want 1/0", done_end, busy_end);
        end
    endtask

    task automatic test_skipped_bits();
        logic [127:0] obs;
        logic [18:0]  hdr;
        logic cnt_ok, busy_ok, early_done, done_end, busy_end;
        logic [38:0] msg;
        msg = 39'h3F_FFFE_A5A5;
        do_load(msg, 1'b0, 4'd1, 64'hC300_0000_0000_0000, 1'b0);
        capture(frame_len(1'b0, 4'd1), obs, cnt_ok, busy_ok, early_done, done_end, busy_end);
        for (int k = 0; k < 19; k++) hdr[18-k] = obs[k];
        total++; if (hdr !== 19'h2A5A5) begin bad++; $display("FAIL skip_header got=%h want=2a5a5", hdr); end
        total++; if (obs[1] !== 1'b1) begin bad++; $display("FAIL skip_bit1 got=%b want=1", obs[1]); end
        total++; if (obs !== exp_stream(msg, 1'b0, 4'd1, 64'hC300_0000_0000_0000)) begin
            bad++; $display("FAIL skip_stream got=%h want=%h", obs, exp_stream(msg, 1'b0, 4'd1, 64'hC300_0000_0000_0000));
        end
        total++; if (done_end !== 1'b1 || busy_end !== 1'b0 || cnt_ok !== 1'b1) begin
            bad++; $display("FAIL skip_done done=%b busy=%b cnt=%b want 1/0/1", done_end, busy_end, cnt_ok);
        end
    endtask

    task automatic test_abort();
        logic seen_done;
        do_load(39'h00_0002_AAAA, 1'b0, 4'd2, 64'hFFFF_0000_0000_0000, 1'b0);
        for (int i = 0; i < 30; i++) give_tick();
        total++; if (bitcnt !== 7'd30 || busy !== 1'b1) begin
            bad++; $display("FAIL abort_pre bitcnt=%0d busy=%b want 30/1", bitcnt, busy);
        end
        abort = 1'b1;
        tick  = 1'b1;
        @(posedge clock);
        @(negedge clock);
        abort = 1'b0;
        tick  = 1'b0;
        total++; if (busy !== 1'b0 || txbit !== 1'b1 || bitcnt !== 7'd0 || done !== 1'b0) begin
            bad++; $display("FAIL abort_idle busy=%b txbit=%b bitcnt=%0d done=%b want 0/1/0/0", busy, txbit, bitcnt, done);
        end
        seen_done = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            if (done !== 1'b0) seen_done = 1'b1;
        end
        total++; if (seen_done !== 1'b0) begin bad++; $display("FAIL abort_no_done got=%b want=0", seen_done); end
    endtask

    task automatic test_start_edge();
        logic [127:0] obs;
        logic cnt_ok, busy_ok, early_done, done_end, busy_end;
        logic [38:0] msg;
        msg = 39'h00_0001_2345;
        do_load(msg, 1'b0, 4'd0, 64'h0, 1'b1);
        total++; if (txbit !== 1'b0 || busy !== 1'b1 || bitcnt !== 7'd0) begin
            bad++; $display("FAIL load_tick_sof txbit=%b busy=%b bitcnt=%0d want 0/1/0", txbit, busy, bitcnt);
        end
        repeat (3) @(negedge clock);
        total++; if (bitcnt !== 7'd0 || txbit !== 1'b0) begin
            bad++; $display("FAIL sof_hold bitcnt=%0d txbit=%b want 0/0", bitcnt, txbit);
        end
        message  = 39'h7F_FFFF_FFFF;
        extended = 1'b1;
        tmlen    = 4'd8;
        data     = '1;
        load     = 1'b1;
        capture(frame_len(1'b0, 4'd0), obs, cnt_ok, busy_ok, early_done, done_end, busy_end);
        load = 1'b0;
        total++; if (obs !== exp_stream(msg, 1'b0, 4'd0, 64'h0)) begin
            bad++; $display("FAIL busy_load_stream got=%h want=%h", obs, exp_stream(msg, 1'b0, 4'd0, 64'h0));
        end
        total++; if (done_end !== 1'b1 || busy_end !== 1'b0 || cnt_ok !== 1'b1) begin
            bad++; $display("FAIL busy_load_done done=%b busy=%b cnt=%b want 1/0/1", done_end, busy_end, cnt_ok);
        end
        @(negedge clock);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL busy_load_queued busy=%b want=0", busy); end
    endtask

    task automatic test_async_reset();
        logic [127:0] obs;
        logic cnt_ok, busy_ok, early_done, done_end, busy_end;
        logic [38:0] msg;
        int target;
        msg    = 39'h15_5555_0F0F;
        target = (CRC_BITS != 0) ? 50 : 42;
        do_load(msg, 1'b1, 4'd1, 64'h5A00_0000_0000_0000, 1'b0);
        for (int i = 0; i < target; i++) give_tick();
        #2 reset = 1'b1;
        #1;
        total++; if (txbit !== 1'b1 || busy !== 1'b0 || bitcnt !== 7'd0 || done !== 1'b0) begin
            bad++; $display("FAIL async_reset txbit=%b busy=%b bitcnt=%0d done=%b want 1/0/0/0", txbit, busy, bitcnt, done);
        end
        @(negedge clock);
        reset = 1'b0;
        do_load(msg, 1'b1, 4'd1, 64'h5A00_0000_0000_0000, 1'b0);
        capture(frame_len(1'b1, 4'd1), obs, cnt_ok, busy_ok, early_done, done_end, busy_end);
        total++; if (obs !== exp_stream(msg, 1'b1, 4'd1, 64'h5A00_0000_0000_0000)) begin
            bad++; $display("FAIL post_reset_stream got=%h want=%h", obs, exp_stream(msg, 1'b1, 4'd1, 64'h5A00_0000_0000_0000));
        end
        total++; if (done_end !== 1'b1 || busy_end !== 1'b0 || cnt_ok !== 1'b1 || early_done !== 1'b0) begin
            bad++; $display("FAIL post_reset_done done=%b busy=%b cnt=%b early=%b want 1/0/1/0", done_end, busy_end, cnt_ok, early_done);
        end
    endtask

    initial begin
        repeat (2) @(posedge clock);
        test_reset();
        test_basic_zero();
        test_ext_clip();
        test_skipped_bits();
        test_abort();
        test_start_edge();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
